// File: rtl/minirisc_ctrl_seq_if.sv
// Instruction handshake, memory strobe and decoded control bundle of the
// miniRISC control sequencer. The sequencer is the slave; the instruction source is the master.
interface minirisc_ctrl_seq_if;
  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high. instr_ready depends only on sequencer state, and
  // the source may hold instr_valid high for as many cycles as it wants.
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ready;

  logic        RegWrite;
  logic        ImmSel;
  logic        ALUSrc;
  logic        CompEnbl;
  logic        ShiftAmntSel;
  logic        ShiftEnbl;
  logic        ShortBr;
  logic        LongBr;
  logic        MemRead;
  logic        MemWrite;
  logic        BranchReg;
  logic [1:0]  ALUOp;
  logic [1:0]  RegDst;
  logic [1:0]  ShiftType;
  logic [1:0]  BranchType;
  logic [1:0]  JumpType;
  logic [1:0]  MemToReg;

  logic        illegal;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output instr, instr_valid, mem_ready,
    input  instr_ready, RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel,
           ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg, ALUOp,
           RegDst, ShiftType, BranchType, JumpType, MemToReg, illegal, halted,
           retired
  );

  modport slave (
    input  instr, instr_valid, mem_ready,
    output instr_ready, RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel,
           ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg, ALUOp,
           RegDst, ShiftType, BranchType, JumpType, MemToReg, illegal, halted,
           retired
  );
endinterface

// File: rtl/minirisc_ctrl_seq.sv
// Decode and control sequencer for the KGP miniRISC datapath: registered control
// bundle, multi-cycle load/store sequencing and a retired-instruction counter.
module minirisc_ctrl_seq (
  input  logic                      clk,
  input  logic                      rst,
  minirisc_ctrl_seq_if.slave        bus,
  output logic [2:0]                dbgState
);

  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, HALT} state_t;

  typedef struct packed {
    logic       regWrite;
    logic       immSel;
    logic       aluSrc;
    logic       compEnbl;
    logic       shiftAmntSel;
    logic       shiftEnbl;
    logic       shortBr;
    logic       longBr;
    logic       memRead;
    logic       memWrite;
    logic       branchReg;
    logic [1:0] aluOp;
    logic [1:0] regDst;
    logic [1:0] shiftType;
    logic [1:0] branchType;
    logic [1:0] jumpType;
    logic [1:0] memToReg;
  } ctrl_t;

  typedef struct packed {
    ctrl_t c;
    logic  bad;
    logic  isMem;
    logic  isHalt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    logic [4:0] fn;
    d  = '0;
    op = ins[31:26];
    fn = ins[4:0];
    case (op)
      6'd0: begin
        d.c.regWrite = 1'b1;
        case (fn)
          5'd0: d.c.aluOp = 2'b01;
          5'd1: begin d.c.aluOp = 2'b01; d.c.compEnbl = 1'b1; end
          5'd2: d.c.aluOp = 2'b10;
          5'd3: d.c.aluOp = 2'b11;
          default: d.bad = 1'b1;
        endcase
      end
      6'd1: begin
        if (fn[4:3] != 2'b00) begin
          d.bad = 1'b1;
        end else begin
          d.c.regWrite     = 1'b1;
          d.c.shiftEnbl    = 1'b1;
          d.c.shiftType    = fn[1:0];
          d.c.shiftAmntSel = fn[2];
        end
      end
      6'd2, 6'd3: begin
        d.c.regWrite = 1'b1;
        d.c.aluSrc   = 1'b1;
        d.c.aluOp    = 2'b01;
        d.c.compEnbl = (op == 6'd3);
      end
      6'd4: begin
        d.isMem      = 1'b1;
        d.c.aluSrc   = 1'b1;
        d.c.immSel   = 1'b1;
        d.c.aluOp    = 2'b01;
        d.c.memRead  = 1'b1;
        d.c.regDst   = 2'b01;
        d.c.memToReg = 2'b01;
      end
      6'd5: begin
        d.isMem      = 1'b1;
        d.c.aluSrc   = 1'b1;
        d.c.immSel   = 1'b1;
        d.c.aluOp    = 2'b01;
        d.c.memWrite = 1'b1;
      end
      6'd6: d.c.branchReg = 1'b1;
      6'd7: begin
        d.c.longBr   = 1'b1;
        d.c.jumpType = fn[1:0];
        // bl links the return address through the register file
        if (fn[1:0] == 2'b01) begin
          d.c.regWrite = 1'b1;
          d.c.regDst   = 2'b10;
          d.c.memToReg = 2'b10;
        end
      end
      6'd8: begin
        d.c.shortBr    = 1'b1;
        d.c.branchType = fn[1:0];
      end
      6'd63: d.isHalt = 1'b1;
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

  state_t      state;
  ctrl_t       ctrl;
  ctrl_t       wbCtrl;
  dec_t        dec;
  logic        illegalQ;
  logic [15:0] retiredQ;
  logic        canAccept;
  logic        accept;
  logic        unusedInstrBits;

  assign dec             = decode(bus.instr);
  assign canAccept       = (state == IDLE) || (state == EXEC);
  assign accept          = canAccept && bus.instr_valid;
  assign unusedInstrBits = ^bus.instr[25:5];

  always_comb begin
    wbCtrl          = '0;
    wbCtrl.regWrite = 1'b1;
    wbCtrl.memToReg = 2'b01;
    wbCtrl.regDst   = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      illegalQ <= 1'b0;
      retiredQ <= '0;
    end else begin
      illegalQ <= 1'b0;
      case (state)
        IDLE, EXEC: begin
          if (state == EXEC && !illegalQ) retiredQ <= retiredQ + 16'd1;
          if (accept) begin
            if (dec.isHalt) begin
              ctrl  <= '0;
              state <= HALT;
            end else if (dec.bad) begin
              ctrl     <= '0;
              illegalQ <= 1'b1;
              state    <= EXEC;
            end else begin
              ctrl  <= dec.c;
              state <= dec.isMem ? MEM : EXEC;
            end
          end else begin
            ctrl  <= '0;
            state <= IDLE;
          end
        end
        MEM: begin
          if (bus.mem_ready) begin
            // the store retires as memory completes; the load retires after WB
            if (ctrl.memWrite) begin
              ctrl     <= '0;
              retiredQ <= retiredQ + 16'd1;
              state    <= IDLE;
            end else begin
              ctrl  <= wbCtrl;
              state <= WB;
            end
          end
        end
        WB: begin
          ctrl     <= '0;
          retiredQ <= retiredQ + 16'd1;
          state    <= IDLE;
        end
        HALT: ctrl <= '0;
        default: begin
          ctrl  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready  = canAccept;
  assign bus.halted       = (state == HALT);
  assign bus.illegal      = illegalQ;
  assign bus.retired      = retiredQ;
  assign bus.RegWrite     = ctrl.regWrite;
  assign bus.ImmSel       = ctrl.immSel;
  assign bus.ALUSrc       = ctrl.aluSrc;
  assign bus.CompEnbl     = ctrl.compEnbl;
  assign bus.ShiftAmntSel = ctrl.shiftAmntSel;
  assign bus.ShiftEnbl    = ctrl.shiftEnbl;
  assign bus.ShortBr      = ctrl.shortBr;
  assign bus.LongBr       = ctrl.longBr;
  assign bus.MemRead      = ctrl.memRead;
  assign bus.MemWrite     = ctrl.memWrite;
  assign bus.BranchReg    = ctrl.branchReg;
  assign bus.ALUOp        = ctrl.aluOp;
  assign bus.RegDst       = ctrl.regDst;
  assign bus.ShiftType    = ctrl.shiftType;
  assign bus.BranchType   = ctrl.branchType;
  assign bus.JumpType     = ctrl.jumpType;
  assign bus.MemToReg     = ctrl.memToReg;
  assign dbgState         = state;

endmodule

// File: tb/tb_minirisc_ctrl_seq.sv
// Directed bench for minirisc_ctrl_seq: decode table plus hand-written
// sequences for back-to-back issue, load/store stalls, halt and reset.
module tb_minirisc_ctrl_seq;

  logic       clk;
  logic       rst;
  logic [2:0] dbgState;
  minirisc_ctrl_seq_if bus ();

  minirisc_ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle bit order: RegWrite(22) ImmSel ALUSrc CompEnbl ShiftAmntSel ShiftEnbl
  // ShortBr LongBr MemRead MemWrite BranchReg(12) ALUOp[11:10] RegDst[9:8]
  // ShiftType[7:6] BranchType[5:4] JumpType[3:2] MemToReg[1:0]
  logic [22:0] ctrlBus;
  assign ctrlBus = {bus.RegWrite, bus.ImmSel, bus.ALUSrc, bus.CompEnbl,
                    bus.ShiftAmntSel, bus.ShiftEnbl, bus.ShortBr, bus.LongBr,
                    bus.MemRead, bus.MemWrite, bus.BranchReg, bus.ALUOp,
                    bus.RegDst, bus.ShiftType, bus.BranchType, bus.JumpType,
                    bus.MemToReg};

  localparam logic [22:0] RW   = 23'd1 << 22;
  localparam logic [22:0] IMM  = 23'd1 << 21;
  localparam logic [22:0] ASRC = 23'd1 << 20;
  localparam logic [22:0] CE   = 23'd1 << 19;
  localparam logic [22:0] SAS  = 23'd1 << 18;
  localparam logic [22:0] SE   = 23'd1 << 17;
  localparam logic [22:0] SB   = 23'd1 << 16;
  localparam logic [22:0] LB   = 23'd1 << 15;
  localparam logic [22:0] MR   = 23'd1 << 14;
  localparam logic [22:0] MW   = 23'd1 << 13;
  localparam logic [22:0] BRG  = 23'd1 << 12;

  function automatic logic [22:0] fld(input logic [1:0] v, input int pos);
    return {21'd0, v} << pos;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [22:0] expCtrl;
    logic        expIll;
  } vec_t;

  vec_t        vecs[16];
  int          nChecks;
  int          nPass;
  logic [15:0] expRet;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one instruction at the current (negedge) time and drop valid after the edge
  task automatic issue(input logic [31:0] ins);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    expRet  = 16'd0;
    rst             = 1'b0;
    bus.instr       = 32'd0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;

    vecs[0]  = '{32'h00000000, RW | fld(2'b01, 10), 1'b0};
    vecs[1]  = '{32'h00000001, RW | fld(2'b01, 10) | CE, 1'b0};
    vecs[2]  = '{32'h00000002, RW | fld(2'b10, 10), 1'b0};
    vecs[3]  = '{32'h00000003, RW | fld(2'b11, 10), 1'b0};
    vecs[4]  = '{32'h00000004, 23'd0, 1'b1};
    vecs[5]  = '{32'h04000005, RW | SE | SAS | fld(2'b01, 6), 1'b0};
    vecs[6]  = '{32'h04000002, RW | SE | fld(2'b10, 6), 1'b0};
    vecs[7]  = '{32'h04000008, 23'd0, 1'b1};
    vecs[8]  = '{32'h08000000, RW | ASRC | fld(2'b01, 10), 1'b0};
    vecs[9]  = '{32'h0C000000, RW | ASRC | fld(2'b01, 10) | CE, 1'b0};
    vecs[10] = '{32'h18000000, BRG, 1'b0};
    vecs[11] = '{32'h1C000001, LB | fld(2'b01, 2) | RW | fld(2'b10, 8) | fld(2'b10, 0), 1'b0};
    vecs[12] = '{32'h1C000002, LB | fld(2'b10, 2), 1'b0};
    vecs[13] = '{32'h20000003, SB | fld(2'b11, 4), 1'b0};
    vecs[14] = '{32'h24000000, 23'd0, 1'b1};
    vecs[15] = '{32'hF8000000, 23'd0, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst ctrl", 32'(ctrlBus), 32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);
    chk("rst halted", 32'(bus.halted), 32'd0);
    chk("rst retired", 32'(bus.retired), 32'd0);
    rst = 1'b1;
    #1 chk("rst ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);

    // Back-to-back addi then and; mem_ready is high but must be ignored
    bus.mem_ready   = 1'b1;
    bus.instr       = 32'h08000000;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr = 32'h00000002;
    @(negedge clk);
    chk("b2b addi ctrl", 32'(ctrlBus), 32'(RW | ASRC | fld(2'b01, 10)));
    chk("b2b addi ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    expRet = expRet + 16'd1;
    chk("b2b and ctrl", 32'(ctrlBus), 32'(RW | fld(2'b10, 10)));
    chk("b2b and ready", 32'(bus.instr_ready), 32'd1);
    chk("b2b retired mid", 32'(bus.retired), 32'(expRet));
    @(negedge clk);
    expRet = expRet + 16'd1;
    chk("b2b idle ctrl", 32'(ctrlBus), 32'd0);
    chk("b2b retired", 32'(bus.retired), 32'(expRet));

    // Decode table, each from IDLE
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].instr);
      @(negedge clk);
      chk($sformatf("vec%0d ctrl", i), 32'(ctrlBus), 32'(vecs[i].expCtrl));
      chk($sformatf("vec%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].expIll));
      chk($sformatf("vec%0d ready", i), 32'(bus.instr_ready), 32'd1);
      @(negedge clk);
      if (!vecs[i].expIll) expRet = expRet + 16'd1;
      chk($sformatf("vec%0d clear", i), 32'(ctrlBus), 32'd0);
      chk($sformatf("vec%0d illegal off", i), 32'(bus.illegal), 32'd0);
      chk($sformatf("vec%0d retired", i), 32'(bus.retired), 32'(expRet));
    end

    // lw with mem_ready low for 3 cycles
    bus.mem_ready = 1'b0;
    issue(32'h10000000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lw mem%0d MemRead", k), 32'(bus.MemRead), 32'd1);
      chk($sformatf("lw mem%0d RegWrite", k), 32'(bus.RegWrite), 32'd0);
      chk($sformatf("lw mem%0d ready", k), 32'(bus.instr_ready), 32'd0);
      if (k == 0)
        chk("lw mem ctrl", 32'(ctrlBus),
            32'(ASRC | IMM | fld(2'b01, 10) | MR | fld(2'b01, 8) | fld(2'b01, 0)));
      if (k == 3) bus.mem_ready = 1'b1;
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("lw wb RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("lw wb MemToReg", 32'(bus.MemToReg), 32'd1);
    chk("lw wb RegDst", 32'(bus.RegDst), 32'd1);
    chk("lw wb MemRead", 32'(bus.MemRead), 32'd0);
    chk("lw wb ready", 32'(bus.instr_ready), 32'd0);
    chk("lw wb retired", 32'(bus.retired), 32'(expRet));
    @(negedge clk);
    expRet = expRet + 16'd1;
    chk("lw idle ctrl", 32'(ctrlBus), 32'd0);
    chk("lw idle ready", 32'(bus.instr_ready), 32'd1);
    chk("lw retired", 32'(bus.retired), 32'(expRet));

    // sw completing immediately
    bus.mem_ready = 1'b1;
    issue(32'h14000000);
    @(negedge clk);
    chk("sw mem ctrl", 32'(ctrlBus), 32'(ASRC | IMM | fld(2'b01, 10) | MW));
    chk("sw mem ready", 32'(bus.instr_ready), 32'd0);
    chk("sw mem retired", 32'(bus.retired), 32'(expRet));
    @(negedge clk);
    expRet = expRet + 16'd1;
    chk("sw idle ctrl", 32'(ctrlBus), 32'd0);
    chk("sw retired", 32'(bus.retired), 32'(expRet));
    chk("sw idle ready", 32'(bus.instr_ready), 32'd1);

    // Reset asserted mid-lw while stalled in MEM
    bus.mem_ready = 1'b0;
    issue(32'h10000000);
    @(negedge clk);
    chk("abort pre MemRead", 32'(bus.MemRead), 32'd1);
    #2 rst = 1'b0;
    #1;
    expRet = 16'd0;
    chk("abort ctrl", 32'(ctrlBus), 32'd0);
    chk("abort retired", 32'(bus.retired), 32'(expRet));
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort after%0d ctrl", k), 32'(ctrlBus), 32'd0);
      chk($sformatf("abort after%0d retired", k), 32'(bus.retired), 32'(expRet));
      chk($sformatf("abort after%0d ready", k), 32'(bus.instr_ready), 32'd1);
    end

    // Halt, then addi offered while halted, then reset
    issue(32'h08000000);
    @(negedge clk);
    expRet = expRet + 16'd1;
    issue(32'hFC000000);
    @(negedge clk);
    chk("halt halted", 32'(bus.halted), 32'd1);
    chk("halt ready", 32'(bus.instr_ready), 32'd0);
    chk("halt ctrl", 32'(ctrlBus), 32'd0);
    chk("halt retired", 32'(bus.retired), 32'(expRet));
    bus.instr       = 32'h08000000;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halt hold%0d halted", k), 32'(bus.halted), 32'd1);
      chk($sformatf("halt hold%0d ctrl", k), 32'(ctrlBus), 32'd0);
      chk($sformatf("halt hold%0d retired", k), 32'(bus.retired), 32'(expRet));
    end
    bus.instr_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("halt rst halted", 32'(bus.halted), 32'd0);
    chk("halt rst retired", 32'(bus.retired), 32'd0);
    chk("halt rst ctrl", 32'(ctrlBus), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("halt rst ready", 32'(bus.instr_ready), 32'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
